// File: rtl/aes_key_expansion.sv
// AES key-schedule generator (128/192/256-bit keys), one 32-bit word per clock.
// Optional KEYEXP_ROUNDKEY_PORT_EN adds an indexed 128-bit round_key read port.
module aes_key_expansion #(
  parameter int unsigned NK = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [0:32*NK-1]       key,
  output logic                   busy,
  output logic                   valid,
  output logic [0:32*4*(NK+7)-1] round_keys
`ifdef KEYEXP_ROUNDKEY_PORT_EN
  ,
  input  logic [3:0]             round_idx,
  output logic [0:127]           round_key
`endif
);

  localparam int unsigned NR = NK + 6;
  localparam int unsigned NW = 4 * (NR + 1);
  localparam int unsigned CW = $clog2(NW);
  localparam int unsigned KW = 3;

  if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
    $error("aes_key_expansion: NK must be 4, 6 or 8");
  end

  typedef enum logic {S_IDLE, S_GEN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [KW-1:0]   kidx_q, kidx_d;
  logic [7:0]      rcon_q, rcon_d;
  logic            busy_d, valid_d;
  logic            load, gen;
  logic [31:0]     w_q [NW];
  logic [31:0]     prev_w, sub_in, sub_w, temp_w, new_w;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward AES S-box
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] s;
    s = 8'h00;
    case (x)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
    endcase
    return s;
  endfunction

  // Next word: kidx_q tracks i % NK so no divider is needed; one shared SubWord
  always_comb begin
    prev_w = w_q[cnt_q - CW'(1)];
    sub_in = (kidx_q == '0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
    sub_w  = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
    if (kidx_q == '0)                     temp_w = sub_w ^ {rcon_q, 24'h0};
    else if (NK == 8 && kidx_q == KW'(4)) temp_w = sub_w;
    else                                  temp_w = prev_w;
    new_w = w_q[cnt_q - CW'(NK)] ^ temp_w;
  end

  // Next-state and control
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kidx_d  = kidx_q;
    rcon_d  = rcon_q;
    busy_d  = busy;
    valid_d = valid;
    load    = 1'b0;
    gen     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = S_GEN;
          busy_d  = 1'b1;
          valid_d = 1'b0;
          cnt_d   = CW'(NK);
          kidx_d  = '0;
          rcon_d  = 8'h01;
        end
      end
      S_GEN: begin
        gen    = 1'b1;
        cnt_d  = cnt_q + CW'(1);
        kidx_d = (kidx_q == KW'(NK - 1)) ? '0 : kidx_q + KW'(1);
        if (kidx_q == '0) rcon_d = xtime(rcon_q);
        if (cnt_q == CW'(NW - 1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      kidx_q  <= '0;
      rcon_q  <= 8'h01;
      busy    <= 1'b0;
      valid   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kidx_q  <= kidx_d;
      rcon_q  <= rcon_d;
      busy    <= busy_d;
      valid   <= valid_d;
    end
  end

  // Schedule storage; words beyond NK keep stale values until rewritten
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NW; i++) w_q[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < NK; i++) w_q[i] <= key[32*i +: 32];
    end else if (gen) begin
      w_q[cnt_q] <= new_w;
    end
  end

  always_comb begin
    for (int i = 0; i < NW; i++) round_keys[32*i +: 32] = w_q[i];
  end

`ifdef KEYEXP_ROUNDKEY_PORT_EN
  always_comb begin
    round_key = '0;
    if (round_idx <= 4'(NR)) begin
      for (int j = 0; j < 4; j++) round_key[32*j +: 32] = w_q[CW'(4 * int'(round_idx) + j)];
    end
  end
`endif

endmodule

// File: tb/tb_aes_key_expansion.sv
// Bench for aes_key_expansion: NK=4/6/8 instances against a GF(2^8)-derived reference schedule.
// Round-key port checks compile in when KEYEXP_ROUNDKEY_PORT_EN is defined.
module tb_aes_key_expansion;

  logic clk = 1'b0;
  logic rst_n;
  logic start4, start6, start8;
  logic [0:127] key4;
  logic [0:191] key6;
  logic [0:255] key8;
  logic busy4, busy6, busy8, valid4, valid6, valid8;
  logic [0:32*44-1] rk4;
  logic [0:32*52-1] rk6;
  logic [0:32*60-1] rk8;
`ifdef KEYEXP_ROUNDKEY_PORT_EN
  logic [3:0]   ridx4, ridx6, ridx8;
  logic [0:127] rkey4, rkey6, rkey8;
`endif

  int nchk = 0;
  int npass = 0;
  logic [7:0]  sbx [256];
  logic [31:0] ref_key [8];
  logic [31:0] ref_w [60];
  logic [7:0]  rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  always #5 clk = ~clk;

  aes_key_expansion #(.NK(4)) u4 (.clk(clk), .rst_n(rst_n), .start(start4), .key(key4),
    .busy(busy4), .valid(valid4), .round_keys(rk4)
`ifdef KEYEXP_ROUNDKEY_PORT_EN
    , .round_idx(ridx4), .round_key(rkey4)
`endif
  );
  aes_key_expansion #(.NK(6)) u6 (.clk(clk), .rst_n(rst_n), .start(start6), .key(key6),
    .busy(busy6), .valid(valid6), .round_keys(rk6)
`ifdef KEYEXP_ROUNDKEY_PORT_EN
    , .round_idx(ridx6), .round_key(rkey6)
`endif
  );
  aes_key_expansion #(.NK(8)) u8 (.clk(clk), .rst_n(rst_n), .start(start8), .key(key8),
    .busy(busy8), .valid(valid8), .round_keys(rk8)
`ifdef KEYEXP_ROUNDKEY_PORT_EN
    , .round_idx(ridx8), .round_key(rkey8)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map
  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = 8'h63;
      for (int r = 0; r < 5; r++) s ^= 8'((inv << r) | (inv >> (8 - r)));
      sbx[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbx[w[31:24]], sbx[w[23:16]], sbx[w[15:8]], sbx[w[7:0]]};
  endfunction

  task automatic ref_expand(input int nk);
    logic [31:0] t;
    for (int i = 0; i < 4 * (nk + 7); i++) begin
      if (i < nk) ref_w[i] = ref_key[i];
      else begin
        t = ref_w[i-1];
        if (i % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon_tab[i/nk-1], 24'h0};
        else if (nk == 8 && i % nk == 4) t = subw(t);
        ref_w[i] = ref_w[i-nk] ^ t;
      end
    end
  endtask

  function automatic logic [31:0] dut_w(input int nk, input int i);
    case (nk)
      4: return rk4[32*i +: 32];
      6: return rk6[32*i +: 32];
      default: return rk8[32*i +: 32];
    endcase
  endfunction

  function automatic logic dut_valid(input int nk);
    return (nk == 4) ? valid4 : (nk == 6) ? valid6 : valid8;
  endfunction

  function automatic logic dut_busy(input int nk);
    return (nk == 4) ? busy4 : (nk == 6) ? busy6 : busy8;
  endfunction

  task automatic set_start(input int nk, input logic v);
    case (nk)
      4: start4 = v;
      6: start6 = v;
      default: start8 = v;
    endcase
  endtask

  task automatic drive_key(input int nk, input logic zero);
    for (int j = 0; j < nk; j++) begin
      case (nk)
        4: key4[32*j +: 32] = zero ? 32'h0 : ref_key[j];
        6: key6[32*j +: 32] = zero ? 32'h0 : ref_key[j];
        default: key8[32*j +: 32] = zero ? 32'h0 : ref_key[j];
      endcase
    end
  endtask

  task automatic load_key(input logic [255:0] k);
    for (int j = 0; j < 8; j++) ref_key[j] = k[255-32*j -: 32];
  endtask

  // Start an expansion; optionally poke a zero-key start at cycle 'poke' while busy
  task automatic run_expand(input int nk, input int poke);
    int cyc;
    drive_key(nk, 1'b0);
    @(negedge clk) set_start(nk, 1'b1);
    @(posedge clk) #1 set_start(nk, 1'b0);
    chk($sformatf("nk%0d_busy_after_start", nk), 128'(dut_busy(nk)), 128'd1);
    chk($sformatf("nk%0d_valid_after_start", nk), 128'(dut_valid(nk)), 128'd0);
    cyc = 0;
    while (!dut_valid(nk) && cyc < 200) begin
      if (cyc + 1 == poke) begin
        drive_key(nk, 1'b1);
        set_start(nk, 1'b1);
      end
      @(posedge clk) #1 set_start(nk, 1'b0);
      cyc++;
    end
    chk($sformatf("nk%0d_latency", nk), 128'(cyc), 128'(4 * (nk + 7) - nk));
    chk($sformatf("nk%0d_busy_done", nk), 128'(dut_busy(nk)), 128'd0);
    ref_expand(nk);
    for (int i = 0; i < 4 * (nk + 7); i++)
      chk($sformatf("nk%0d_w%0d", nk, i), 128'(dut_w(nk, i)), 128'(ref_w[i]));
  endtask

  task automatic chk_kat(input int nk);
    logic [31:0] e [5];
    int base;
    case (nk)
      4: begin e = '{32'ha0fafe17, 32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6}; base = 40; end
      6: begin e = '{32'hfe0c91f7, 32'he98ba06f, 32'h448c773c, 32'h8ecc7204, 32'h01002202}; base = 48; end
      default: begin e = '{32'h9ba35411, 32'hfe4890d1, 32'he6188d0b, 32'h046df344, 32'h706c631e}; base = 56; end
    endcase
    chk($sformatf("kat%0d_w%0d", nk, nk), 128'(dut_w(nk, nk)), 128'(e[0]));
    for (int j = 0; j < 4; j++)
      chk($sformatf("kat%0d_w%0d", nk, base + j), 128'(dut_w(nk, base + j)), 128'(e[j+1]));
  endtask

  initial begin
    int nks [3] = '{4, 6, 8};
    build_sbox();
    rst_n = 1'b0;
    start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
    key4 = '0; key6 = '0; key8 = '0;
`ifdef KEYEXP_ROUNDKEY_PORT_EN
    ridx4 = '0; ridx6 = '0; ridx8 = '0;
`endif
    #12;
    chk("rst_busy", 128'({busy4, busy6, busy8}), 128'd0);
    chk("rst_valid", 128'({valid4, valid6, valid8}), 128'd0);
    chk("rst_rk", 128'({|rk4, |rk6, |rk8}), 128'd0);
    @(negedge clk) rst_n = 1'b1;

    load_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
    run_expand(4, -1);
    chk_kat(4);
`ifdef KEYEXP_ROUNDKEY_PORT_EN
    ridx4 = 4'd0;  #1 chk("ridx0", 128'(rkey4), 128'h2b7e151628aed2a6abf7158809cf4f3c);
    ridx4 = 4'd10; #1 chk("ridx10", 128'(rkey4), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    ridx4 = 4'd11; #1 chk("ridx11", 128'(rkey4), 128'h0);
    ridx4 = 4'd15; #1 chk("ridx15", 128'(rkey4), 128'h0);
`endif
    repeat (5) @(posedge clk);
    #1;
    chk("hold_valid", 128'(valid4), 128'd1);
    chk("hold_w43", 128'(dut_w(4, 43)), 128'(ref_w[43]));

    load_key({192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0});
    run_expand(6, -1);
    chk_kat(6);

    load_key(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4);
    run_expand(8, -1);
    chk_kat(8);
`ifdef KEYEXP_ROUNDKEY_PORT_EN
    ridx8 = 4'd14; #1 chk("ridx14_nk8", 128'(rkey8), {ref_w[56], ref_w[57], ref_w[58], ref_w[59]});
`endif

    // Start while busy must be ignored, including its new key
    load_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
    run_expand(4, 10);
    chk_kat(4);

    // Random keys; each run restarts an instance whose valid is already high
    for (int r = 0; r < 2; r++) begin
      foreach (nks[n]) begin
        for (int j = 0; j < 8; j++) ref_key[j] = $urandom;
        run_expand(nks[n], -1);
      end
    end

    // Asynchronous reset in the middle of an expansion
    load_key({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0});
    drive_key(4, 1'b0);
    @(negedge clk) start4 = 1'b1;
    @(posedge clk) #1 start4 = 1'b0;
    repeat (20) @(posedge clk);
    #1 chk("midrun_busy", 128'(busy4), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 128'(busy4), 128'd0);
    chk("abort_valid", 128'(valid4), 128'd0);
    chk("abort_rk", 128'(|rk4), 128'd0);
    @(negedge clk) rst_n = 1'b1;
    run_expand(4, -1);
    chk_kat(4);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
